// File: rtl/clk_div_pkg.sv
// Shared types, constants and the high-time clamp helper for the clk_div_multi divider.
// Build option: CLK_DIV_SYNC_EN (see clk_div_multi.sv) adds a global phase-alignment input.
package clk_div_pkg;

    typedef enum logic {
        CH_IDLE,
        CH_RUN
    } chan_state_t;

    localparam int CLK_DIV_MIN_RATIO = 2;

    // Widest counter the helper below handles; channels zero-extend into it.
    localparam int CLK_DIV_MAX_WIDTH = 64;

    // Turns a requested high time into the one actually used.
    // 0 means half the period (rounded down), and anything that would keep
    // the clock high for the whole period is clipped to one cycle short of it.
    function automatic logic [CLK_DIV_MAX_WIDTH-1:0] eff_high(
        input logic [CLK_DIV_MAX_WIDTH-1:0] ratio,
        input logic [CLK_DIV_MAX_WIDTH-1:0] high
    );
        if (high == '0)
            return ratio >> 1;
        else if (high >= ratio)
            return ratio - 1'b1;
        else
            return high;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: IDLE/RUN FSM, period counter, active and shadow configuration.
// Configuration only changes at a boundary (idle, period wrap or sync) so clk_out never glitches.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEF_RATIO = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr,
    input  logic             sync,
    input  logic [WIDTH-1:0] wr_ratio,
    input  logic [WIDTH-1:0] wr_high,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    chan_state_t      state, state_next;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] act_ratio, act_ratio_next;
    logic [WIDTH-1:0] act_high, act_high_next;
    logic [WIDTH-1:0] shadow_ratio, shadow_high;
    logic             pending_next;
    logic             clk_out_next, tick_next;
    logic             boundary, load;
    logic [WIDTH-1:0] load_ratio, load_high;

    // Boundary detection, configuration hand-over and next counter/outputs.
    // A write landing on the boundary cycle itself is used directly (write-through).
    always_comb begin
        boundary       = 1'b0;
        load           = 1'b0;
        load_ratio     = shadow_ratio;
        load_high      = shadow_high;
        act_ratio_next = act_ratio;
        act_high_next  = act_high;
        pending_next   = pending;
        state_next     = state;
        cnt_next       = '0;
        clk_out_next   = 1'b0;
        tick_next      = 1'b0;

        boundary = (state == CH_IDLE) || sync || (cnt == act_ratio - WIDTH'(1));

        if (wr) begin
            load_ratio = wr_ratio;
            load_high  = wr_high;
        end

        load = boundary && (wr || pending);
        if (load) begin
            act_ratio_next = load_ratio;
            act_high_next  = WIDTH'(eff_high(CLK_DIV_MAX_WIDTH'(load_ratio),
                                             CLK_DIV_MAX_WIDTH'(load_high)));
            pending_next   = 1'b0;
        end else if (wr) begin
            pending_next = 1'b1;
        end

        if (enable) begin
            state_next   = CH_RUN;
            cnt_next     = boundary ? '0 : cnt + WIDTH'(1);
            tick_next    = boundary;
            clk_out_next = (cnt_next < act_high_next);
        end else begin
            state_next = CH_IDLE;
        end
    end

    // State, counter, registered outputs and configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CH_IDLE;
            cnt          <= '0;
            clk_out      <= 1'b0;
            tick         <= 1'b0;
            act_ratio    <= WIDTH'(DEF_RATIO);
            act_high     <= WIDTH'(DEF_RATIO / 2);
            shadow_ratio <= '0;
            shadow_high  <= '0;
            pending      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            clk_out   <= clk_out_next;
            tick      <= tick_next;
            act_ratio <= act_ratio_next;
            act_high  <= act_high_next;
            pending   <= pending_next;
            if (wr) begin
                shadow_ratio <= wr_ratio;
                shadow_high  <= wr_high;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: config decode, write validation, channel array.
// Build option: define CLK_DIV_SYNC_EN to add sync_in, which restarts every running
// channel at count 0 on the next cycle for phase alignment.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 32,
    parameter int DEF_RATIO = 2,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_ratio,
    input  logic [WIDTH-1:0]  cfg_high,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync_in,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic              cfg_err
);

    logic cfg_ok;
    logic sync_all;

`ifdef CLK_DIV_SYNC_EN
    assign sync_all = sync_in;
`else
    assign sync_all = 1'b0;
`endif

    assign cfg_ok = (cfg_ratio >= WIDTH'(CLK_DIV_MIN_RATIO)) && (32'(cfg_ch) < NUM_CH);

    // Rejected writes produce a single-cycle error pulse and touch no channel.
    always_ff @(posedge clk_in) begin
        if (reset)
            cfg_err <= 1'b0;
        else
            cfg_err <= cfg_wr && !cfg_ok;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .WIDTH     (WIDTH),
            .DEF_RATIO (DEF_RATIO)
        ) u_ch (
            .clk      (clk_in),
            .reset    (reset),
            .enable   (enable[i]),
            .wr       (cfg_wr && cfg_ok && (cfg_ch == CH_W'(i))),
            .sync     (sync_all),
            .wr_ratio (cfg_ratio),
            .wr_high  (cfg_high),
            .clk_out  (clk_out[i]),
            .tick     (tick[i]),
            .pending  (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (3 channels, 8-bit counters).
// Build option: CLK_DIV_SYNC_EN enables the phase-alignment scenario.
module tb_clk_div_multi;

    localparam int NUM_CH = 3;
    localparam int WIDTH  = 8;

    logic              clk_in = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] enable;
    logic              cfg_wr;
    logic [1:0]        cfg_ch;
    logic [WIDTH-1:0]  cfg_ratio;
    logic [WIDTH-1:0]  cfg_high;
`ifdef CLK_DIV_SYNC_EN
    logic              sync_in;
`endif
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] cfg_pending;
    logic              cfg_err;

    int pass_cnt  = 0;
    int check_cnt = 0;

    clk_div_multi #(
        .NUM_CH    (NUM_CH),
        .WIDTH     (WIDTH),
        .DEF_RATIO (2)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .enable      (enable),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_ratio   (cfg_ratio),
        .cfg_high    (cfg_high),
`ifdef CLK_DIV_SYNC_EN
        .sync_in     (sync_in),
`endif
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    // Advance one clock; outputs are then stable for the new cycle.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = '0;
        cfg_wr    = 1'b0;
        cfg_ch    = '0;
        cfg_ratio = '0;
        cfg_high  = '0;
`ifdef CLK_DIV_SYNC_EN
        sync_in   = 1'b0;
`endif
        step();
        reset = 1'b0;
    endtask

    task automatic write_cfg(input logic [1:0] ch, input int ratio, input int high);
        cfg_wr    = 1'b1;
        cfg_ch    = ch;
        cfg_ratio = WIDTH'(ratio);
        cfg_high  = WIDTH'(high);
    endtask

    task automatic test_reset();
        do_reset();
        check_cnt++;
        if ({clk_out, tick, cfg_pending, cfg_err} !== 10'b0)
            $display("[TB] FAIL reset_outputs: got %b required 0", {clk_out, tick, cfg_pending, cfg_err});
        else pass_cnt++;
    endtask

    task automatic test_default_ratio();
        logic exp;
        do_reset();
        enable[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp = (i % 2 == 0);
            check_cnt++;
            if (clk_out[0] !== exp || tick[0] !== exp)
                $display("[TB] FAIL default_ratio c%0d: clk %b tick %b required %b", i, clk_out[0], tick[0], exp);
            else pass_cnt++;
        end
        enable[0] = 1'b0;
        step();
        check_cnt++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0)
            $display("[TB] FAIL disable_idle: clk %b tick %b required 0 0", clk_out[0], tick[0]);
        else pass_cnt++;
    endtask

    task automatic test_ratio5();
        logic exp_clk, exp_tick;
        do_reset();
        enable[1] = 1'b1;
        step();
        write_cfg(2'd1, 5, 0);
        step();
        cfg_wr = 1'b0;
        check_cnt++;
        if (cfg_pending[1] !== 1'b1 || clk_out[1] !== 1'b0)
            $display("[TB] FAIL ratio5_pending: pend %b clk %b required 1 0", cfg_pending[1], clk_out[1]);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_clk  = (i % 5) < 2;
            exp_tick = (i % 5) == 0;
            check_cnt++;
            if (clk_out[1] !== exp_clk || tick[1] !== exp_tick || cfg_pending[1] !== 1'b0)
                $display("[TB] FAIL ratio5 c%0d: clk %b tick %b pend %b required %b %b 0",
                         i, clk_out[1], tick[1], cfg_pending[1], exp_clk, exp_tick);
            else pass_cnt++;
        end
    endtask

    task automatic test_clamp();
        logic exp_clk, exp_tick;
        do_reset();
        write_cfg(2'd2, 6, 9);
        enable[2] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            cfg_wr   = 1'b0;
            exp_clk  = (i % 6) < 5;
            exp_tick = (i % 6) == 0;
            check_cnt++;
            if (clk_out[2] !== exp_clk || tick[2] !== exp_tick)
                $display("[TB] FAIL clamp c%0d: clk %b tick %b required %b %b",
                         i, clk_out[2], tick[2], exp_clk, exp_tick);
            else pass_cnt++;
        end
    endtask

    task automatic test_errors();
        logic exp;
        do_reset();
        enable[0] = 1'b1;
        step();
        write_cfg(2'd0, 1, 0);
        step();
        check_cnt++;
        if (cfg_err !== 1'b1 || cfg_pending !== 3'b000 || clk_out[0] !== 1'b0)
            $display("[TB] FAIL err_ratio1: err %b pend %b clk %b required 1 000 0", cfg_err, cfg_pending, clk_out[0]);
        else pass_cnt++;
        write_cfg(2'd3, 4, 0);
        step();
        cfg_wr = 1'b0;
        check_cnt++;
        if (cfg_err !== 1'b1 || cfg_pending !== 3'b000 || clk_out[0] !== 1'b1 || tick[0] !== 1'b1)
            $display("[TB] FAIL err_bad_ch: err %b pend %b clk %b tick %b required 1 000 1 1",
                     cfg_err, cfg_pending, clk_out[0], tick[0]);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step();
            exp = (i % 2 == 1);
            check_cnt++;
            if (cfg_err !== 1'b0 || clk_out[0] !== exp)
                $display("[TB] FAIL err_unchanged c%0d: err %b clk %b required 0 %b", i, cfg_err, clk_out[0], exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_write_through();
        logic exp_clk, exp_tick;
        do_reset();
        enable[0] = 1'b1;
        step();
        step();
        write_cfg(2'd0, 7, 0);
        for (int i = 0; i < 14; i++) begin
            step();
            cfg_wr   = 1'b0;
            exp_clk  = (i % 7) < 3;
            exp_tick = (i % 7) == 0;
            check_cnt++;
            if (clk_out[0] !== exp_clk || tick[0] !== exp_tick || cfg_pending[0] !== 1'b0)
                $display("[TB] FAIL write_through c%0d: clk %b tick %b pend %b required %b %b 0",
                         i, clk_out[0], tick[0], cfg_pending[0], exp_clk, exp_tick);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        logic exp;
        do_reset();
        write_cfg(2'd1, 8, 0);
        enable[1] = 1'b1;
        step();
        cfg_wr = 1'b0;
        step();
        write_cfg(2'd1, 5, 0);
        step();
        cfg_wr = 1'b0;
        step();
        check_cnt++;
        if (cfg_pending[1] !== 1'b1 || clk_out[1] !== 1'b1)
            $display("[TB] FAIL reset_mid_pre: pend %b clk %b required 1 1", cfg_pending[1], clk_out[1]);
        else pass_cnt++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_cnt++;
        if ({clk_out, tick, cfg_pending, cfg_err} !== 10'b0)
            $display("[TB] FAIL reset_mid_clear: got %b required 0", {clk_out, tick, cfg_pending, cfg_err});
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step();
            exp = (i % 2 == 0);
            check_cnt++;
            if (clk_out[1] !== exp || tick[1] !== exp)
                $display("[TB] FAIL reset_mid_def c%0d: clk %b tick %b required %b", i, clk_out[1], tick[1], exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic exp_clk;
        do_reset();
        write_cfg(2'd1, 8, 0);
        enable[1] = 1'b1;
        step();
        write_cfg(2'd1, 5, 0);
        step();
        write_cfg(2'd1, 3, 1);
        step();
        cfg_wr = 1'b0;
        check_cnt++;
        if (cfg_pending[1] !== 1'b1 || clk_out[1] !== 1'b1 || tick[1] !== 1'b0)
            $display("[TB] FAIL b2b_pending: pend %b clk %b tick %b required 1 1 0", cfg_pending[1], clk_out[1], tick[1]);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) step();
        for (int i = 0; i < 6; i++) begin
            step();
            exp_clk = (i % 3) < 1;
            check_cnt++;
            if (clk_out[1] !== exp_clk || tick[1] !== exp_clk || cfg_pending[1] !== 1'b0)
                $display("[TB] FAIL b2b c%0d: clk %b tick %b pend %b required %b %b 0",
                         i, clk_out[1], tick[1], cfg_pending[1], exp_clk, exp_clk);
            else pass_cnt++;
        end
    endtask

`ifdef CLK_DIV_SYNC_EN
    task automatic test_sync();
        do_reset();
        write_cfg(2'd0, 4, 0);
        enable[0] = 1'b1;
        step();
        write_cfg(2'd1, 6, 0);
        enable[1] = 1'b1;
        step();
        cfg_wr = 1'b0;
        step();
        check_cnt++;
        if (tick[1:0] !== 2'b00)
            $display("[TB] FAIL sync_pre: tick %b required 00", tick[1:0]);
        else pass_cnt++;
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check_cnt++;
        if (tick[1:0] !== 2'b11 || clk_out[1:0] !== 2'b11)
            $display("[TB] FAIL sync_align: tick %b clk %b required 11 11", tick[1:0], clk_out[1:0]);
        else pass_cnt++;
        step();
        check_cnt++;
        if (tick[1:0] !== 2'b00 || clk_out[1:0] !== 2'b11)
            $display("[TB] FAIL sync_post: tick %b clk %b required 00 11", tick[1:0], clk_out[1:0]);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_default_ratio();
        test_ratio5();
        test_clamp();
        test_errors();
        test_write_through();
        test_reset_mid();
        test_back_to_back();
`ifdef CLK_DIV_SYNC_EN
        test_sync();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
